arp_sequencer: RTL and testbench

//  Parametrised successor to the top-level arpeggiator FSM. Generates the phase address
//  and advance strobe for the quarter-sine table that feeds the PWM block. Steps through
//  N_STEPS pitch ratios of a switch-selected base note, in up, down, ping-pong or hold order.
//  A debounced toggle turns arpeggiation on and off. When off, the block holds the base note.

---
 rtl/arp_pkg.sv | 27 ++
 rtl/phase_divider.sv | 42 ++++
 rtl/arp_sequencer.sv | 135 +++++++++++++
 tb/tb_arp_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared constants and types for the arpeggiator sequencer.
package arp_pkg;

    localparam int STEP_W = 3;

    // Pitch divisors in quarters: div_lim = P * RATIO_Q4[step] / 4
    localparam logic [3:0] RATIO_Q4 [0:7] = '{4'd8, 4'd5, 4'd6, 4'd4, 4'd5, 4'd6, 4'd4, 4'd8};

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    function automatic logic [31:0] scaled_limit(input logic [31:0] period, input logic [3:0] ratio);
        logic [31:0] lim;
        lim = (period * {28'd0, ratio}) >> 2;
        if (lim < 32'd2) begin
            lim = 32'd2;
        end else begin
            lim = lim;
        end
        return lim;
    endfunction

endpackage

// File: rtl/phase_divider.sv
// Phase-address divider: one addr step and one addr_tick pulse every div_lim cycles.
module phase_divider
    import arp_pkg::*;
#(
    parameter int DIV_W  = 13,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  div_lim,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_tick
);

    logic [DIV_W-1:0]  div_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              addr_tick_r;
    logic              wrap_s;

    // >= rather than == so a shrinking limit never lets the counter run past it
    assign wrap_s = (div_cnt_r >= (div_lim - DIV_W'(1)));

    // Counter, address advance and tick pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r   <= '0;
            addr_r      <= '0;
            addr_tick_r <= 1'b0;
        end else if (wrap_s) begin
            div_cnt_r   <= '0;
            addr_r      <= addr_r + ADDR_W'(1);
            addr_tick_r <= 1'b1;
        end else begin
            div_cnt_r   <= div_cnt_r + DIV_W'(1);
            addr_tick_r <= 1'b0;
        end
    end

    assign addr      = addr_r;
    assign addr_tick = addr_tick_r;

endmodule

// File: rtl/arp_sequencer.sv
// Arpeggiator top: toggle edge logic, step timer, step sequencer and period pipeline
// driving the phase divider for the quarter-sine table.
module arp_sequencer
    import arp_pkg::*;
#(
    parameter int N_STEPS     = 4,
    parameter int STEP_TICKS  = 50_000_000,
    parameter int BASE_OFFSET = 746,
    parameter int ADDR_W      = 8,
    parameter int DIV_W       = 13
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [7:0]        sw_base,
    input  logic              toggle,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_tick,
    output logic [2:0]        step,
    output logic              arp_on
);

    localparam int TMR_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STEP_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
    localparam logic [31:0]       LIM_RST   = scaled_limit(32'(BASE_OFFSET), RATIO_Q4[0]);

    logic              tog_prev_r;
    logic              arp_on_r;
    logic [STEP_W-1:0] step_r;
    logic              dir_up_r;
    logic [TMR_W-1:0]  timer_r;
    logic [DIV_W-1:0]  p_r;
    logic [DIV_W-1:0]  div_lim_r;

    logic              tog_edge_s;
    logic              tc_s;
    logic [STEP_W-1:0] step_nx_s;
    logic              dir_nx_s;
    logic [31:0]       lim_full_s;

    assign tog_edge_s = toggle & ~tog_prev_r;
    assign tc_s       = arp_on_r & (timer_r == TMR_LAST);

    // Next pattern index for the current mode
    always_comb begin
        step_nx_s = step_r;
        dir_nx_s  = dir_up_r;
        case (mode_e'(mode))
            MODE_UP:   step_nx_s = (step_r == STEP_LAST) ? STEP_W'(0) : step_r + STEP_W'(1);
            MODE_DOWN: step_nx_s = (step_r == STEP_W'(0)) ? STEP_LAST : step_r - STEP_W'(1);
            MODE_PINGPONG: begin
                if (N_STEPS == 1) begin
                    step_nx_s = STEP_W'(0);
                end else if (dir_up_r) begin
                    if (step_r == STEP_LAST) begin
                        step_nx_s = step_r - STEP_W'(1);
                        dir_nx_s  = 1'b0;
                    end else begin
                        step_nx_s = step_r + STEP_W'(1);
                    end
                end else begin
                    if (step_r == STEP_W'(0)) begin
                        step_nx_s = step_r + STEP_W'(1);
                        dir_nx_s  = 1'b1;
                    end else begin
                        step_nx_s = step_r - STEP_W'(1);
                    end
                end
            end
            MODE_HOLD: step_nx_s = step_r;
            default:   step_nx_s = step_r;
        endcase
    end

    // Toggle handling and step timer; a toggle edge overrides a same-cycle advance
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            tog_prev_r <= 1'b0;
            arp_on_r   <= 1'b0;
            step_r     <= '0;
            dir_up_r   <= 1'b1;
            timer_r    <= '0;
        end else begin
            tog_prev_r <= toggle;
            if (tog_edge_s) begin
                arp_on_r <= ~arp_on_r;
                step_r   <= '0;
                timer_r  <= '0;
                if (!arp_on_r) begin
                    dir_up_r <= 1'b1;
                end
            end else if (arp_on_r) begin
                if (tc_s) begin
                    timer_r  <= '0;
                    step_r   <= step_nx_s;
                    dir_up_r <= dir_nx_s;
                end else begin
                    timer_r <= timer_r + TMR_W'(1);
                end
            end else begin
                step_r  <= '0;
                timer_r <= '0;
            end
        end
    end

    assign lim_full_s = scaled_limit(32'(p_r), RATIO_Q4[step_r]);

    // Two-stage period pipeline; reset values match the base note at step 0
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            p_r       <= DIV_W'(BASE_OFFSET);
            div_lim_r <= DIV_W'(LIM_RST);
        end else begin
            p_r       <= DIV_W'(BASE_OFFSET) + DIV_W'(sw_base);
            div_lim_r <= DIV_W'(lim_full_s);
        end
    end

    phase_divider #(
        .DIV_W  (DIV_W),
        .ADDR_W (ADDR_W)
    ) u_div (
        .clk       (CLK100MHZ),
        .rst_n     (CPU_RESETN),
        .div_lim   (div_lim_r),
        .addr      (addr),
        .addr_tick (addr_tick)
    );

    assign step   = step_r;
    assign arp_on = arp_on_r;

endmodule

// File: tb/tb_arp_sequencer.sv
// Directed bench for arp_sequencer with STEP_TICKS=100, N_STEPS=4.
module tb_arp_sequencer;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN = 1'b0;
    logic [7:0] sw_base = 8'd0;
    logic       toggle = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] addr;
    logic       addr_tick;
    logic [2:0] step;
    logic       arp_on;

    int errors = 0;
    int checks = 0;

    arp_sequencer #(
        .N_STEPS     (4),
        .STEP_TICKS  (100),
        .BASE_OFFSET (746),
        .ADDR_W      (8),
        .DIV_W       (13)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .CPU_RESETN (CPU_RESETN),
        .sw_base    (sw_base),
        .toggle     (toggle),
        .mode       (mode),
        .addr       (addr),
        .addr_tick  (addr_tick),
        .step       (step),
        .arp_on     (arp_on)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int gap);
        gap = 0;
        do begin
            @(negedge CLK100MHZ);
            gap++;
        end while (addr_tick !== 1'b1 && gap < 6000);
        if (addr_tick !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout: observed no addr_tick in %0d cycles, expected a tick", gap);
        end
    endtask

    task automatic wait_step_change(input logic [2:0] old);
        int n;
        n = 0;
        do begin
            @(negedge CLK100MHZ);
            n++;
        end while (step === old && n < 300);
        if (step === old) begin
            checks++;
            errors++;
            $error("FAIL step_timeout: observed step %0d unchanged, expected an advance", step);
        end
    endtask

    task automatic settle_gap(input string tag, input int exp);
        int g;
        wait_tick(g);
        wait_tick(g);
        chk(tag, 32'(g), 32'(exp));
    endtask

    initial begin
        int         g;
        logic [7:0] a0;
        logic [2:0] pp_seq [7];
        logic [2:0] dn_seq [3];
        pp_seq = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        dn_seq = '{3'd0, 3'd3, 3'd2};

        // Reset state
        repeat (3) @(negedge CLK100MHZ);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_tick", 32'(addr_tick), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_arp_on", 32'(arp_on), 32'd0);
        CPU_RESETN = 1'b1;

        // Base note with arpeggiation off: 2*746
        wait_tick(g);
        a0 = addr;
        wait_tick(g);
        chk("base_gap", 32'(g), 32'd1492);
        chk("base_addr_inc", 32'(addr), 32'(a0 + 8'd1));
        chk("base_arp_off", 32'(arp_on), 32'd0);

        // Enable, mode up
        mode   = 2'd0;
        toggle = 1'b1;
        @(negedge CLK100MHZ);
        chk("en_arp_on", 32'(arp_on), 32'd1);
        chk("en_step", 32'(step), 32'd0);
        repeat (99) @(negedge CLK100MHZ);
        chk("up_before_tc", 32'(step), 32'd0);
        @(negedge CLK100MHZ);
        chk("up_step1", 32'(step), 32'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (100) @(negedge CLK100MHZ);
            chk("up_seq", 32'(step), 32'((i + 2) % 4));
        end

        // Ping-pong from step 0, direction up
        mode = 2'd2;
        for (int i = 0; i < 7; i++) begin
            repeat (100) @(negedge CLK100MHZ);
            chk("pingpong_seq", 32'(step), 32'(pp_seq[i]));
        end

        // Hold freezes step at 1
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            repeat (100) @(negedge CLK100MHZ);
            chk("hold_step", 32'(step), 32'd1);
        end

        // Down wraps 0 -> 3
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            repeat (100) @(negedge CLK100MHZ);
            chk("down_seq", 32'(step), 32'(dn_seq[i]));
        end

        // Settled tick spacing per step, held in hold mode
        mode = 2'd3;
        settle_gap("gap_step2", 1119);
        mode = 2'd1;
        wait_step_change(3'd2);
        chk("down_to_1", 32'(step), 32'd1);
        mode = 2'd3;
        settle_gap("gap_step1", 932);
        mode = 2'd1;
        wait_step_change(3'd1);
        chk("down_to_0", 32'(step), 32'd0);
        mode = 2'd3;
        settle_gap("gap_step0", 1492);
        mode = 2'd1;
        wait_step_change(3'd0);
        chk("down_wrap_3", 32'(step), 32'd3);
        mode = 2'd3;
        settle_gap("gap_step3", 746);

        // Disable
        toggle = 1'b0;
        @(negedge CLK100MHZ);
        toggle = 1'b1;
        @(negedge CLK100MHZ);
        chk("dis_arp_on", 32'(arp_on), 32'd0);
        chk("dis_step", 32'(step), 32'd0);

        // sw_base=255 reaches div_lim two cycles later: (746+255)*8/4
        repeat (3) @(negedge CLK100MHZ);
        sw_base = 8'd255;
        @(negedge CLK100MHZ);
        chk("divlim_1cyc", 32'(dut.div_lim_r), 32'd1492);
        @(negedge CLK100MHZ);
        chk("divlim_2cyc", 32'(dut.div_lim_r), 32'd2002);
        settle_gap("gap_sw255", 2002);

        // Address wrap 255 -> 0
        force dut.u_div.addr_r = 8'd255;
        #1;
        release dut.u_div.addr_r;
        chk("addr_forced", 32'(addr), 32'd255);
        wait_tick(g);
        chk("addr_wrap", 32'(addr), 32'd0);

        // Toggle edge in the same cycle as the terminal count
        mode   = 2'd0;
        toggle = 1'b0;
        @(negedge CLK100MHZ);
        toggle = 1'b1;
        @(negedge CLK100MHZ);
        chk("co_en", 32'(arp_on), 32'd1);
        repeat (98) @(negedge CLK100MHZ);
        toggle = 1'b0;
        @(negedge CLK100MHZ);
        chk("co_pre_step", 32'(step), 32'd0);
        toggle = 1'b1;
        @(negedge CLK100MHZ);
        chk("co_arp_on", 32'(arp_on), 32'd0);
        chk("co_step", 32'(step), 32'd0);

        // Reset mid-note
        toggle = 1'b0;
        @(negedge CLK100MHZ);
        toggle = 1'b1;
        @(negedge CLK100MHZ);
        repeat (150) @(negedge CLK100MHZ);
        chk("pre_rst_step", 32'(step), 32'd1);
        CPU_RESETN = 1'b0;
        toggle     = 1'b0;
        @(negedge CLK100MHZ);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_tick", 32'(addr_tick), 32'd0);
        chk("mid_rst_step", 32'(step), 32'd0);
        chk("mid_rst_arp_on", 32'(arp_on), 32'd0);
        CPU_RESETN = 1'b1;
        repeat (5) @(negedge CLK100MHZ);
        chk("post_rst_arp_on", 32'(arp_on), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
